// File: rtl/pong_score_display.sv
// Pong scoreboard: two BCD player scores, win detection, and a 4-digit
// multiplexed active-low seven-segment driver scanned from the 1 kHz strobe.
module pong_score_display #(
    parameter int WIN_SCORE = 11,
    parameter int BLINK_BIT = 8
) (
    input  logic       clk_100MHz,
    input  logic       rst_n,
    input  logic       i_1000Hz,
    input  logic       i_point_l,
    input  logic       i_point_r,
    input  logic       i_new_game,
    output logic [3:0] o_an,
    output logic [6:0] o_seg,
    output logic       o_game_over,
    output logic       o_winner
);

    typedef enum logic {PLAY, OVER} state_t;

    localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {((v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1), 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    logic       r_1k_q, r_1k_d;
    logic [1:0] idx_q, idx_d;
    logic [8:0] blink_q, blink_d;
    logic [7:0] l_score_q, l_score_d, r_score_q, r_score_d;
    state_t     state_q, state_d;
    logic       winner_q, winner_d;
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;

    logic       tick;
    logic [7:0] l_inc, r_inc;
    logic       l_win, r_win;
    logic [3:0] digit;
    logic       blank;

    assign tick  = i_1000Hz & ~r_1k_q;
    assign l_inc = bcd_inc(l_score_q);
    assign r_inc = bcd_inc(r_score_q);
    assign l_win = i_point_l && (l_inc == WIN_BCD);
    assign r_win = i_point_r && (r_inc == WIN_BCD);

    always_comb begin
        r_1k_d    = i_1000Hz;
        idx_d     = idx_q + {1'b0, tick};
        blink_d   = blink_q + {8'd0, tick};
        state_d   = state_q;
        winner_d  = winner_q;
        l_score_d = l_score_q;
        r_score_d = r_score_q;
        if (i_new_game) begin
            l_score_d = 8'h00;
            r_score_d = 8'h00;
            state_d   = PLAY;
            winner_d  = 1'b0;
        end else if (state_q == PLAY) begin
            if (i_point_l) l_score_d = l_inc;
            if (i_point_r) r_score_d = r_inc;
            // A simultaneous win goes to the left player.
            if (l_win || r_win) begin
                state_d  = OVER;
                winner_d = ~l_win;
            end
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    digit = r_score_q[3:0];
            2'd1:    digit = r_score_q[7:4];
            2'd2:    digit = l_score_q[3:0];
            default: digit = l_score_q[7:4];
        endcase
        // idx_q[1] selects the left player; the loser is the side opposite winner_q.
        blank = (idx_q[0] && digit == 4'd0) ||
                (state_q == OVER && blink_q[BLINK_BIT] && (idx_q[1] == winner_q));
        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank ? 7'b1111111 : seg7(digit);
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_1k_q    <= 1'b0;
            idx_q     <= 2'd0;
            blink_q   <= 9'd0;
            l_score_q <= 8'h00;
            r_score_q <= 8'h00;
            state_q   <= PLAY;
            winner_q  <= 1'b0;
            an_q      <= 4'b1111;
            seg_q     <= 7'b1111111;
        end else begin
            r_1k_q    <= r_1k_d;
            idx_q     <= idx_d;
            blink_q   <= blink_d;
            l_score_q <= l_score_d;
            r_score_q <= r_score_d;
            state_q   <= state_d;
            winner_q  <= winner_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign o_an        = an_q;
    assign o_seg       = seg_q;
    assign o_game_over = (state_q == OVER);
    assign o_winner    = winner_q;

endmodule

// File: tb/tb_pong_score_display.sv
// Directed bench for pong_score_display: scan order, BCD carry, win detection,
// loser blink, new-game override and asynchronous reset.
module tb_pong_score_display;

    logic       clk_100MHz = 1'b0;
    logic       rst_n      = 1'b0;
    logic       i_1000Hz   = 1'b0;
    logic       i_point_l  = 1'b0;
    logic       i_point_r  = 1'b0;
    logic       i_new_game = 1'b0;
    logic [3:0] o_an;
    logic [6:0] o_seg;
    logic       o_game_over;
    logic       o_winner;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         m_l = 0, m_r = 0;
    logic       m_over = 1'b0, m_win = 1'b0;
    logic [1:0] m_idx = 2'd0;
    logic [8:0] m_blink = 9'd0;

    always #5 clk_100MHz = ~clk_100MHz;

    pong_score_display #(.WIN_SCORE(11), .BLINK_BIT(8)) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .i_1000Hz   (i_1000Hz),
        .i_point_l  (i_point_l),
        .i_point_r  (i_point_r),
        .i_new_game (i_new_game),
        .o_an       (o_an),
        .o_seg      (o_seg),
        .o_game_over(o_game_over),
        .o_winner   (o_winner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input logic [1:0] i);
        logic [3:0] a;
        a    = 4'b1111;
        a[i] = 1'b0;
        return a;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [1:0] i);
        int   s, dig;
        logic left;
        left = i[1];
        s    = left ? m_l : m_r;
        dig  = i[0] ? s / 10 : s % 10;
        if (i[0] && dig == 0) return 7'b1111111;
        if (m_over && m_blink[8] && (left == m_win)) return 7'b1111111;
        return seg_of(dig);
    endfunction

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    // One strobe rising edge: anode must hold for one edge, then move.
    task automatic tick_check(input string tag);
        logic [1:0] old;
        old = m_idx;
        i_1000Hz = 1'b1;
        step();
        m_idx++;
        m_blink++;
        check({tag, "_an_hold"}, o_an, an_of(old));
        step();
        check({tag, "_an"}, o_an, an_of(m_idx));
        check({tag, "_seg"}, o_seg, exp_seg(m_idx));
        i_1000Hz = 1'b0;
        step();
    endtask

    task automatic tick_fast();
        i_1000Hz = 1'b1;
        step();
        i_1000Hz = 1'b0;
        step();
        m_idx++;
        m_blink++;
    endtask

    task automatic frame(input string tag);
        repeat (4) tick_check(tag);
    endtask

    task automatic advance_blink(input logic b);
        for (int n = 0; n < 600 && m_blink[8] !== b; n++) tick_fast();
    endtask

    task automatic point(input logic pl, input logic pr, input logic ng);
        i_point_l  = pl;
        i_point_r  = pr;
        i_new_game = ng;
        step();
        i_point_l  = 1'b0;
        i_point_r  = 1'b0;
        i_new_game = 1'b0;
        if (ng) begin
            m_l = 0; m_r = 0; m_over = 1'b0; m_win = 1'b0;
        end else if (!m_over) begin
            if (pl) m_l++;
            if (pr) m_r++;
            if ((pl && m_l == 11) || (pr && m_r == 11)) begin
                m_over = 1'b1;
                m_win  = !(pl && m_l == 11);
            end
        end
        check("pt_game_over", o_game_over, m_over);
        check("pt_winner", o_winner, m_win);
    endtask

    initial begin
        #22;
        check("rst_an", o_an, 4'b1111);
        check("rst_seg", o_seg, 7'b1111111);
        check("rst_game_over", o_game_over, 1'b0);
        check("rst_winner", o_winner, 1'b0);

        step();
        rst_n = 1'b1;
        step();
        check("first_an", o_an, 4'b1110);
        check("first_seg", o_seg, 7'b1000000);
        repeat (5) step();
        check("idle_an", o_an, 4'b1110);

        // Two full frames of the scan with leading-zero blanking
        frame("scan_a");
        frame("scan_b");

        // Right to 10 exercises the 9 -> 10 carry
        repeat (10) point(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick_check("r10");
            if (m_idx == 2'd0) check("r10_ones_lit", o_seg, 7'b1000000);
            if (m_idx == 2'd1) check("r10_tens_lit", o_seg, 7'b1111001);
        end

        // Both at 10, then simultaneous point: both 11, left wins the tie
        repeat (10) point(1'b1, 1'b0, 1'b0);
        frame("both10");
        point(1'b1, 1'b1, 1'b0);
        check("tie_game_over_lit", o_game_over, 1'b1);
        check("tie_winner_lit", o_winner, 1'b0);
        point(1'b0, 1'b1, 1'b0);
        point(1'b1, 1'b0, 1'b0);
        advance_blink(1'b0);
        frame("over_noblink");
        advance_blink(1'b1);
        for (int k = 0; k < 4; k++) begin
            tick_check("over_blink");
            if (m_idx == 2'd0) check("blink_r_ones_blank", o_seg, 7'b1111111);
            if (m_idx == 2'd2) check("blink_l_ones_lit", o_seg, 7'b1111001);
        end

        // New game overrides a simultaneous point pulse
        point(1'b1, 1'b0, 1'b1);
        check("ng_game_over_lit", o_game_over, 1'b0);
        frame("after_ng");

        // Left wins alone on the 11th pulse
        repeat (11) point(1'b1, 1'b0, 1'b0);
        check("lwin_lit", o_game_over, 1'b1);
        frame("lwin");

        // Right wins alone; left digits blink
        point(1'b0, 1'b0, 1'b1);
        repeat (11) point(1'b0, 1'b1, 1'b0);
        check("rwin_winner_lit", o_winner, 1'b1);
        advance_blink(1'b0);
        advance_blink(1'b1);
        frame("rwin_blink");

        // Asynchronous reset mid-cycle while in OVER
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", o_an, 4'b1111);
        check("async_rst_seg", o_seg, 7'b1111111);
        check("async_rst_game_over", o_game_over, 1'b0);
        check("async_rst_winner", o_winner, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
